mock_sccb_slave: RTL and testbench
==================================

MOCK_SCCB_SLAVE -- requirements
Module: mock_sccb_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h21: 7-bit slave ID; the write ID is 0x42 and the read ID is 0x43.
REQ-002 SHALL have parameter REG_AW, default 8: sub-address width, 1..8; register depth = 2**REG_AW.
REQ-003 SHALL have parameter PID_VAL, default 8'h76: reset content of register 0x0A, when 0x0A < depth.
REQ-004 SHALL have parameter VER_VAL, default 8'h73: reset content of register 0x0B, when 0x0B < depth.
REQ-005 SHALL have port clk, input, 1 bit: system clock, at least 8x the SCL frequency.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port scl, input, 1 bit: SCCB clock from the master.
REQ-008 SHALL have port sda, inout, 1 bit: SCCB data; driven only low-or-Z by this block, never actively high.
REQ-009 SHALL have port wr_stb, output, 1 bit: one-clk pulse when a written byte is committed.
REQ-010 SHALL have port wr_addr, output, REG_AW bits: register address of the last committed write.
REQ-011 SHALL have port wr_data, output, 8 bits: data of the last committed write.
REQ-012 SHALL have port busy, output, 1 bit: high from a matched START until STOP or NACK.

Function
REQ-013 SHALL pass scl and sda through 2-flop synchronisers; all edge and condition detection SHALL use the synchronised values.
REQ-014 SHALL detect the bus conditions on synchronised scl high: sda falling = START or repeated START; sda rising = STOP.
REQ-015 START/STOP detection SHALL take priority over any SCL edge seen in the same clk.
REQ-016 START SHALL enter DEV_ID from any state.
REQ-017 STOP SHALL enter IDLE from any state and release sda.
REQ-018 SHALL implement these states: IDLE, DEV_ID, ACK_DEV, SUB, ACK_SUB, WDATA, ACK_WR, RDATA, MACK, IGNORE.
REQ-019 SHALL sample sda on each SCL rising edge, MSB first, with an 8-bit shift and a 3-bit counter.
REQ-020 After 8 DEV_ID bits: if ID[7:1]==DEV_ADDR, SHALL go to ACK_DEV; on mismatch SHALL go to IGNORE with no ACK, and remain there until START or STOP.
REQ-021 SHALL drive the ACK low from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-022 The ACK drive SHALL appear at most 4 clk after the raw SCL falling edge.
REQ-023 Write ID: the first byte after ACK_DEV SHALL load the register pointer (low REG_AW bits); each following byte SHALL be written to reg[pointer], pulse wr_stb, and then increment the pointer.
REQ-024 Read ID: SHALL present reg[pointer] MSB first, shifting each bit on the SCL falling edge; the first bit SHALL be driven on the falling edge that ends ACK_DEV.
REQ-025 In read mode, after bit 8 SHALL release sda and sample the master ACK on SCL rising.
REQ-026 Master ACK (0) in read mode SHALL increment the pointer and stream the next byte.
REQ-027 Master NACK (1) in read mode SHALL go to IGNORE.
REQ-028 Pointer increment SHALL wrap from depth-1 to 0.
REQ-029 The pointer SHALL persist across transactions, which supports the SCCB two-phase read (write sub-address, STOP, then read ID).
REQ-030 A write and a read of the same address SHALL never occur in the same clk; the write SHALL commit at the rising edge of bit 8, before any read of that address.

Reset
REQ-031 On rst_n low, SHALL immediately (asynchronously) release sda, set state=IDLE, and clear the pointer, counter, busy, wr_stb, wr_addr and wr_data.
REQ-032 On rst_n low, SHALL clear all registers to 0 except PID_VAL and VER_VAL.
REQ-033 A reset in mid-transfer SHALL abort the transfer; the block SHALL ignore the bus until the next START.

Configuration
REQ-034 SHALL support macro MOCK_SCCB_NACK_INJECT_EN.
REQ-035 When MOCK_SCCB_NACK_INJECT_EN is defined, SHALL add input port nack_inject (1 bit).
REQ-036 When MOCK_SCCB_NACK_INJECT_EN is defined and nack_inject is high at an ACK slot, SHALL withhold the ACK (sda stays Z), skip any pending wr_stb, and go to IGNORE.
REQ-037 When MOCK_SCCB_NACK_INJECT_EN is undefined, the port SHALL be absent and all ACKs SHALL be given per REQ-020..REQ-023.

Verification
REQ-038 Scenario: write 0x42, 0x12, 0x80, STOP -> three ACKs; wr_stb=1 once with wr_addr=0x12 and wr_data=0x80.
REQ-039 Scenario: two-phase read: 0x42, 0x0A, STOP; then 0x43, master NACK -> bytes 0x76 received.
REQ-040 Scenario: burst read 0x43 at pointer 0x0A with master ACK -> bytes 0x76, 0x73; stops after master NACK.
REQ-041 Scenario: REG_AW=4, write 0x42, 0x0F, 0xAA, 0xBB -> writes reg 0xF=0xAA and reg 0x0=0xBB (pointer wrap).
REQ-042 Scenario: ID 0x60 -> sda stays Z for the whole transfer, busy=0, no wr_stb.
REQ-043 Scenario: rst_n low during bit 4 of a read byte -> sda goes Z within 0 clk; after reset, reads 0x0A = 0x76.

Source files
------------

// File: rtl/mock_sccb_slave.sv
// mock_sccb_slave: behavioural SCCB register slave (write ID {DEV_ADDR,0}, read ID {DEV_ADDR,1}).
// Latency: ACK and read data reach sda 3 clk after the raw SCL falling edge (2-flop sync + edge detect).
// Backpressure: none; SCL-timed bus, sda is only pulled low or released. Macro MOCK_SCCB_NACK_INJECT_EN adds nack_inject.
`timescale 1ns/1ps
module mock_sccb_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h21,
   parameter int         REG_AW   = 8,
   parameter logic [7:0] PID_VAL  = 8'h76,
   parameter logic [7:0] VER_VAL  = 8'h73
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl,
   inout  wire               sda,
   output logic              wr_stb,
   output logic [REG_AW-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
`ifdef MOCK_SCCB_NACK_INJECT_EN
   ,
   input  logic              nack_inject
`endif
);

   localparam int DEPTH = 1 << REG_AW;

   typedef enum logic [3:0] {
      IDLE, DEV_ID, ACK_DEV, SUB, ACK_SUB, WDATA, ACK_WR, RDATA, MACK, IGNORE
   } state_t;

   state_t              state_q, state_d;
   logic                scl_s1_q, scl_s2_q, scl_s3_q;
   logic                sda_s1_q, sda_s2_q, sda_s3_q;
   logic [7:0]          shift_q, shift_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [REG_AW-1:0]   ptr_q, ptr_d;
   logic                rw_q, rw_d;
   logic                ack_q, ack_d;     // pulling sda low for an ACK slot
   logic                tx_q, tx_d;       // presenting read data from shift_q[7]
   logic                nack_q, nack_d;   // ACK of the byte just received is withheld
   logic                mok_q, mok_d;     // master ACKed, next falling edge starts a new byte
   logic                busy_q, busy_d;
   logic                wr_stb_q, wr_stb_d;
   logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic [7:0]          regs_q [DEPTH];
   logic                reg_we;
   logic                nack_w;
   logic                scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]          rx_byte;

`ifdef MOCK_SCCB_NACK_INJECT_EN
   assign nack_w = nack_inject;
`else
   assign nack_w = 1'b0;
`endif

   // bus sampling: two sync flops plus one history flop for edge detection; idle bus is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_s1_q <= 1'b1;
         scl_s2_q <= 1'b1;
         scl_s3_q <= 1'b1;
         sda_s1_q <= 1'b1;
         sda_s2_q <= 1'b1;
         sda_s3_q <= 1'b1;
      end else begin
         scl_s1_q <= scl;
         scl_s2_q <= scl_s1_q;
         scl_s3_q <= scl_s2_q;
         sda_s1_q <= sda;
         sda_s2_q <= sda_s1_q;
         sda_s3_q <= sda_s2_q;
      end
   end

   assign scl_rise  = scl_s2_q & ~scl_s3_q;
   assign scl_fall  = ~scl_s2_q & scl_s3_q;
   assign start_det = scl_s2_q & sda_s3_q & ~sda_s2_q;
   assign stop_det  = scl_s2_q & ~sda_s3_q & sda_s2_q;
   assign rx_byte   = {shift_q[6:0], sda_s2_q};

   // open-drain output: only ever low or released
   assign sda = (ack_q | (tx_q & ~shift_q[7])) ? 1'b0 : 1'bz;

   assign wr_stb  = wr_stb_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;

   // state register and protocol datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= 8'h00;
         cnt_q     <= 3'd0;
         ptr_q     <= '0;
         rw_q      <= 1'b0;
         ack_q     <= 1'b0;
         tx_q      <= 1'b0;
         nack_q    <= 1'b0;
         mok_q     <= 1'b0;
         busy_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         rw_q      <= rw_d;
         ack_q     <= ack_d;
         tx_q      <= tx_d;
         nack_q    <= nack_d;
         mok_q     <= mok_d;
         busy_q    <= busy_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // register file: reset image carries the ID bytes, single write port driven by the FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i == 10)      regs_q[i] <= PID_VAL;
            else if (i == 11) regs_q[i] <= VER_VAL;
            else              regs_q[i] <= 8'h00;
         end
      end else if (reg_we) begin
         regs_q[ptr_q] <= rx_byte;
      end
   end

   // next-state: bus conditions override everything, otherwise act on SCL edges
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      rw_d      = rw_q;
      ack_d     = ack_q;
      tx_d      = tx_q;
      nack_d    = nack_q;
      mok_d     = mok_q;
      busy_d    = busy_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      reg_we    = 1'b0;

      if (start_det) begin
         state_d = DEV_ID;
         cnt_d   = 3'd0;
         ack_d   = 1'b0;
         tx_d    = 1'b0;
         mok_d   = 1'b0;
      end else if (stop_det) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         ack_d   = 1'b0;
         tx_d    = 1'b0;
         mok_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, IGNORE: begin
            end
            DEV_ID: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     rw_d   = rx_byte[0];
                     nack_d = nack_w;
                     if (rx_byte[7:1] == DEV_ADDR) begin
                        state_d = ACK_DEV;
                        busy_d  = ~nack_w;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
            end
            SUB, WDATA: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     nack_d  = nack_w;
                     state_d = (state_q == SUB) ? ACK_SUB : ACK_WR;
                     if (!nack_w) begin
                        if (state_q == SUB) begin
                           ptr_d = rx_byte[REG_AW-1:0];
                        end else begin
                           // commit on the 8th rising edge, ahead of any read of this address
                           reg_we    = 1'b1;
                           wr_stb_d  = 1'b1;
                           wr_addr_d = ptr_q;
                           wr_data_d = rx_byte;
                           ptr_d     = ptr_q + 1'b1;
                        end
                     end
                  end
               end
            end
            ACK_DEV, ACK_SUB, ACK_WR: begin
               // first falling edge opens the ACK slot, second one closes it
               if (scl_fall) begin
                  if (!ack_q) begin
                     if (nack_q) state_d = IGNORE;
                     else        ack_d   = 1'b1;
                  end else begin
                     ack_d = 1'b0;
                     cnt_d = 3'd0;
                     if (state_q == ACK_DEV && rw_q) begin
                        state_d = RDATA;
                        shift_d = regs_q[ptr_q];
                        tx_d    = 1'b1;
                     end else if (state_q == ACK_DEV) begin
                        state_d = SUB;
                     end else begin
                        state_d = WDATA;
                     end
                  end
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = MACK;
                     mok_d   = 1'b0;
                  end
               end else if (scl_fall) begin
                  shift_d = {shift_q[6:0], 1'b0};
               end
            end
            MACK: begin
               if (scl_fall) begin
                  if (mok_q) begin
                     state_d = RDATA;
                     shift_d = regs_q[ptr_q];
                     tx_d    = 1'b1;
                     cnt_d   = 3'd0;
                     mok_d   = 1'b0;
                  end else begin
                     tx_d = 1'b0;
                  end
               end else if (scl_rise) begin
                  if (!sda_s2_q) begin
                     mok_d = 1'b1;
                     ptr_d = ptr_q + 1'b1;
                  end else begin
                     state_d = IGNORE;
                     tx_d    = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (state_d == IGNORE || state_d == IDLE) busy_d = 1'b0;
   end

endmodule

// File: tb/tb_mock_sccb_slave.sv
// tb_mock_sccb_slave: directed SCCB master driving two slaves on one open-drain bus.
// Latency: master bit period 160 ns against a 10 ns system clock.
// Backpressure: none; slaves answer within each SCL low phase.
`timescale 1ns/1ps
module tb_mock_sccb_slave;

   localparam int Q = 40;

   logic       clk, rst_n, scl_m, m_sda_low;
   wire        sda;
   logic       wr_stb1, busy1, wr_stb2, busy2;
   logic [7:0] wr_addr1, wr_data1, wr_data2;
   logic [3:0] wr_addr2;

   int n_chk  = 0;
   int n_pass = 0;
   int stb1_n = 0, stb2_n = 0, drive_n = 0, busy1_n = 0;
   logic [7:0] stb1_addr = 8'h00, stb1_data = 8'h00;
   logic [7:0] stb2_addr [4];
   logic [7:0] stb2_data [4];

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   mock_sccb_slave u_dut (
      .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda),
      .wr_stb(wr_stb1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1)
`ifdef MOCK_SCCB_NACK_INJECT_EN
      , .nack_inject(1'b0)
`endif
   );

   mock_sccb_slave #(.DEV_ADDR(7'h3C), .REG_AW(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda(sda),
      .wr_stb(wr_stb2), .wr_addr(wr_addr2), .wr_data(wr_data2), .busy(busy2)
`ifdef MOCK_SCCB_NACK_INJECT_EN
      , .nack_inject(1'b0)
`endif
   );

   initial begin
      clk = 1'b0;
      #2;
      forever #5 clk = ~clk;
   end

   // observe strobes, slave drive while master is released, and busy occupancy
   always @(negedge clk) begin
      if (wr_stb1) begin
         stb1_n    <= stb1_n + 1;
         stb1_addr <= wr_addr1;
         stb1_data <= wr_data1;
      end
      if (wr_stb2) begin
         stb2_n <= stb2_n + 1;
         if (stb2_n < 4) begin
            stb2_addr[stb2_n[1:0]] <= {4'h0, wr_addr2};
            stb2_data[stb2_n[1:0]] <= wr_data2;
         end
      end
      if (!m_sda_low && sda === 1'b0) drive_n <= drive_n + 1;
      if (busy1) busy1_n <= busy1_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; #Q;
      scl_m = 1'b1;     #Q;
      m_sda_low = 1'b1; #Q;
      scl_m = 1'b0;     #Q;
   endtask

   task automatic bus_stop();
      m_sda_low = 1'b1; #Q;
      scl_m = 1'b1;     #Q;
      m_sda_low = 1'b0; #Q;
   endtask

   task automatic clk_bit(input logic b, output logic r);
      m_sda_low = ~b; #Q;
      scl_m = 1'b1;   #Q;
      r = sda;        #Q;
      scl_m = 1'b0;   #Q;
   endtask

   // ack = slave pulled low mid-high; early = low already 41 ns after the falling edge
   task automatic write_byte(input logic [7:0] d, output logic ack, output logic early);
      logic r;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
      m_sda_low = 1'b0; #1;
      early = (sda === 1'b0);
      #(Q - 1);
      scl_m = 1'b1; #Q;
      ack = (sda === 1'b0); #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, r);
         d[i] = r;
      end
      clk_bit(~mack, r);
   endtask

   task automatic set_ptr(input logic [7:0] id, input logic [7:0] sub);
      logic ack, early;
      bus_start();
      write_byte(id, ack, early);
      check("ptr id ack", ack, 1);
      write_byte(sub, ack, early);
      check("ptr sub ack", ack, 1);
      bus_stop();
   endtask

   initial begin
      logic       ack, early;
      logic [7:0] d;
      int         snap_drive, snap_busy, snap_stb;

      rst_n = 1'b0; scl_m = 1'b1; m_sda_low = 1'b0;
      #100;
      check("rst sda", sda, 1);
      check("rst busy", busy1, 0);
      check("rst wr_stb", wr_stb1, 0);
      check("rst wr_addr", wr_addr1, 0);
      check("rst wr_data", wr_data1, 0);
      rst_n = 1'b1;
      #Q;

      // write 0x42 0x12 0x80
      bus_start();
      write_byte(8'h42, ack, early);
      check("w id ack", ack, 1);
      check("ack within 4 clk", early, 1);
      check("busy after id", busy1, 1);
      write_byte(8'h12, ack, early);
      check("w sub ack", ack, 1);
      write_byte(8'h80, ack, early);
      check("w data ack", ack, 1);
      bus_stop();
      check("busy after stop", busy1, 0);
      check("stb count", stb1_n, 1);
      check("stb addr", stb1_addr, 8'h12);
      check("stb data", stb1_data, 8'h80);

      // read back the written register
      set_ptr(8'h42, 8'h12);
      bus_start();
      write_byte(8'h43, ack, early);
      check("r id ack", ack, 1);
      read_byte(1'b0, d);
      check("readback 0x12", d, 8'h80);
      check("busy after nack", busy1, 0);
      bus_stop();

      // two-phase read of PID
      set_ptr(8'h42, 8'h0A);
      bus_start();
      write_byte(8'h43, ack, early);
      read_byte(1'b0, d);
      check("pid read", d, 8'h76);
      bus_stop();

      // burst read from 0x0A (pointer unchanged by the NACKed read)
      bus_start();
      write_byte(8'h43, ack, early);
      read_byte(1'b1, d);
      check("burst b0", d, 8'h76);
      read_byte(1'b0, d);
      check("burst b1", d, 8'h73);
      check("burst busy", busy1, 0);
      read_byte(1'b1, d);
      check("after nack released", d, 8'hFF);
      bus_stop();

      // foreign ID: nobody answers
      snap_drive = drive_n; snap_busy = busy1_n; snap_stb = stb1_n;
      bus_start();
      write_byte(8'h60, ack, early);
      check("foreign id ack", ack, 0);
      write_byte(8'h55, ack, early);
      check("foreign data ack", ack, 0);
      bus_stop();
      check("foreign sda drive", drive_n - snap_drive, 0);
      check("foreign busy", busy1_n - snap_busy, 0);
      check("foreign stb", stb1_n - snap_stb, 0);

      // REG_AW=4 slave: pointer wraps 0xF -> 0x0
      bus_start();
      write_byte(8'h78, ack, early);
      check("aw4 id ack", ack, 1);
      write_byte(8'h0F, ack, early);
      check("aw4 sub ack", ack, 1);
      write_byte(8'hAA, ack, early);
      check("aw4 d0 ack", ack, 1);
      write_byte(8'hBB, ack, early);
      check("aw4 d1 ack", ack, 1);
      bus_stop();
      check("aw4 stb count", stb2_n, 2);
      check("aw4 addr0", stb2_addr[0], 8'h0F);
      check("aw4 data0", stb2_data[0], 8'hAA);
      check("aw4 addr1", stb2_addr[1], 8'h00);
      check("aw4 data1", stb2_data[1], 8'hBB);
      set_ptr(8'h78, 8'h0F);
      bus_start();
      write_byte(8'h79, ack, early);
      read_byte(1'b1, d);
      check("aw4 read 0xF", d, 8'hAA);
      read_byte(1'b0, d);
      check("aw4 read 0x0", d, 8'hBB);
      bus_stop();
      check("aw4 other stb", stb1_n, 1);

      // reset in the middle of a read byte (slave driving bit 3 = 0)
      set_ptr(8'h42, 8'h0A);
      bus_start();
      write_byte(8'h43, ack, early);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, ack);
      check("mid read drive", sda, 0);
      rst_n = 1'b0;
      #1;
      check("rst releases sda", sda, 1);
      check("rst clears busy", busy1, 0);
      #49;
      rst_n = 1'b1;
      #Q;
      bus_stop();
      bus_start();
      write_byte(8'h43, ack, early);
      read_byte(1'b0, d);
      check("ptr cleared", d, 8'h00);
      bus_stop();
      set_ptr(8'h42, 8'h12);
      bus_start();
      write_byte(8'h43, ack, early);
      read_byte(1'b0, d);
      check("reg cleared", d, 8'h00);
      bus_stop();
      set_ptr(8'h42, 8'h0A);
      bus_start();
      write_byte(8'h43, ack, early);
      read_byte(1'b0, d);
      check("pid after rst", d, 8'h76);
      bus_stop();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
